// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column scan, frame-level debounce with multi-key
// rejection, and a fall-through keycode FIFO with valid/ready output.
module keypad_scanner #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned KW        = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            kpdreset,
  output logic [COLS-1:0] column,
  input  logic [ROWS-1:0] row,
  output logic [KW-1:0]   keydata,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_down,
  output logic            multikey,
  output logic            overflow,
  input  logic            clr_ovf
);

  localparam int unsigned NKEYS = ROWS * COLS;
  localparam int unsigned DW    = $clog2(SCAN_DIV);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned NW    = $clog2(NKEYS + 1);
  localparam int unsigned SW    = 4;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned OW    = PW + 1;

  // scan state
  logic             scan_en;
  logic [DW-1:0]    div_q;
  logic [CW-1:0]    col_q;
  logic [CW-1:0]    col_n;
  logic [NKEYS-1:0] snap_q;
  logic [NKEYS-1:0] snap_full;
  logic             sample;
  logic             frame_end;

  // debounce state
  logic [NW-1:0]    nset;
  logic [KW-1:0]    one_code;
  logic             cand_none;
  logic             multi;
  logic             same;
  logic [SW-1:0]    stable_cnt;
  logic [SW-1:0]    cnt_n;
  logic             prev_none;
  logic [KW-1:0]    prev_code;
  logic [KW-1:0]    held_code;
  logic             accept;
  logic             push_req;
  logic             rel_req;

  // fifo state
  logic [KW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_n;
  logic [OW-1:0]    count_q;
  logic [OW-1:0]    count_n;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             drop;
  logic [KW-1:0]    head_n;

  assign sample    = scan_en && (div_q == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_q == CW'(COLS - 1));

  // next column index, wrapping at the last column
  always_comb begin
    col_n = col_q;
    if (sample) begin
      col_n = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
    end
  end

  // snapshot including the row sample taken this cycle
  always_comb begin
    snap_full = snap_q;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (sample && (col_q == CW'(c))) begin
          snap_full[r*int'(COLS) + c] = ~row[r];
        end
      end
    end
  end

  // key count and code of the (last) set key in the frame
  always_comb begin
    nset     = '0;
    one_code = '0;
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (snap_full[i]) begin
        nset     = nset + NW'(1);
        one_code = KW'(i);
      end
    end
  end

  // frame candidate comparison and acceptance decisions
  always_comb begin
    cand_none = (nset == '0);
    multi     = (nset > NW'(1));
    same      = (cand_none == prev_none) && (cand_none || (one_code == prev_code));
    if (!same) begin
      cnt_n = SW'(1);
    end else if (stable_cnt == SW'(DEBOUNCE)) begin
      cnt_n = stable_cnt;
    end else begin
      cnt_n = stable_cnt + SW'(1);
    end
    accept   = frame_end && !multi && (cnt_n == SW'(DEBOUNCE));
    push_req = accept && !cand_none && (!key_down || (one_code != held_code));
    rel_req  = accept && cand_none && key_down;
  end

  // fifo pointer/occupancy update and next head entry
  always_comb begin
    pop   = key_valid && key_ready;
    full  = (count_q == OW'(FIFO_DEPTH));
    wr_en = push_req && (!full || pop);
    drop  = push_req && full && !pop;
    rd_n  = pop ? rd_q + PW'(1) : rd_q;
    case ({wr_en, pop})
      2'b10:   count_n = count_q + OW'(1);
      2'b01:   count_n = count_q - OW'(1);
      default: count_n = count_q;
    endcase
    head_n = (wr_en && (rd_n == wr_q)) ? one_code : mem[rd_n];
  end

  // column divider, column drive and snapshot capture
  always_ff @(posedge clk or posedge kpdreset) begin
    if (kpdreset) begin
      scan_en <= 1'b0;
      div_q   <= '0;
      col_q   <= '0;
      snap_q  <= '0;
      column  <= '1;
    end else begin
      scan_en <= 1'b1;
      column  <= ~(COLS'(1) << col_n);
      if (scan_en) begin
        col_q <= col_n;
        if (sample) begin
          div_q  <= '0;
          snap_q <= snap_full;
        end else begin
          div_q  <= div_q + DW'(1);
        end
      end
    end
  end

  // per-frame debounce and accepted key state
  always_ff @(posedge clk or posedge kpdreset) begin
    if (kpdreset) begin
      stable_cnt <= '0;
      prev_none  <= 1'b1;
      prev_code  <= '0;
      held_code  <= '0;
      key_down   <= 1'b0;
      multikey   <= 1'b0;
    end else if (frame_end) begin
      multikey <= multi;
      if (multi) begin
        stable_cnt <= '0;
      end else begin
        stable_cnt <= cnt_n;
        prev_none  <= cand_none;
        prev_code  <= one_code;
      end
      if (push_req) begin
        key_down  <= 1'b1;
        held_code <= one_code;
      end else if (rel_req) begin
        key_down  <= 1'b0;
      end
    end
  end

  // keycode fifo storage, registered head and sticky overflow
  always_ff @(posedge clk or posedge kpdreset) begin
    if (kpdreset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      keydata   <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_q] <= one_code;
        wr_q      <= wr_q + PW'(1);
      end
      rd_q      <= rd_n;
      count_q   <= count_n;
      keydata   <= head_n;
      key_valid <= (count_n != '0);
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
